// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_div_pkg;

  localparam int CH_IDX_W               = 4;
  localparam int DEFAULT_HALF_1HZ_50MHZ = 25000000;
  localparam int SIM_HALF               = 5;
  localparam int MAX_DIV_W              = 32;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // A zero half-period would never reach its terminal count, so it means "fastest".
  function automatic logic [MAX_DIV_W-1:0] clampHalf(input logic [MAX_DIV_W-1:0] half);
    clampHalf = (half == '0) ? MAX_DIV_W'(1) : half;
  endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: counter, shadow/active half-period, registered clko and tick.
// Optional phase-sync input present when CLOCK_DIV_MULTI_PHASE_SYNC_EN is defined.
module clock_div_ch
  import clock_div_pkg::*;
#(
  parameter int DIV_W        = 27,
  parameter int DEFAULT_HALF = DEFAULT_HALF_1HZ_50MHZ
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] data,
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
  input  logic             sync,
`endif
  output logic             clko,
  output logic             tick
);

  localparam logic [DIV_W-1:0] RESET_HALF = DIV_W'(clampHalf(MAX_DIV_W'(DEFAULT_HALF)));

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_shadowHalf;
  logic [DIV_W-1:0] r_activeHalf;
  logic             r_clko;
  logic             r_tick;

  logic [DIV_W-1:0] w_data;
  logic [DIV_W-1:0] w_nextActive;
  logic             w_terminal;
  logic             w_sync;

  assign w_data       = DIV_W'(clampHalf(MAX_DIV_W'(data)));
  assign w_terminal   = (r_count == (r_activeHalf - DIV_W'(1)));
  // A write landing on a reload edge bypasses the shadow so it is not lost.
  assign w_nextActive = wr ? w_data : r_shadowHalf;

`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_shadowHalf <= RESET_HALF;
      r_activeHalf <= RESET_HALF;
      r_clko       <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      if (wr) begin
        r_shadowHalf <= w_data;
      end
      if (!en) begin
        r_count <= '0;
        r_clko  <= 1'b0;
        r_tick  <= 1'b0;
      end else if (w_sync) begin
        r_count      <= '0;
        r_clko       <= 1'b0;
        r_tick       <= 1'b0;
        r_activeHalf <= w_nextActive;
      end else if (w_terminal) begin
        r_count      <= '0;
        r_clko       <= ~r_clko;
        r_tick       <= ~r_clko;
        r_activeHalf <= w_nextActive;
      end else begin
        r_count <= r_count + DIV_W'(1);
        r_tick  <= 1'b0;
      end
    end
  end

  assign clko = r_clko;
  assign tick = r_tick;

endmodule

// File: rtl/clock_div_multi.sv
// NUM_CH independent programmable square-wave dividers with per-period tick.
// Define CLOCK_DIV_MULTI_PHASE_SYNC_EN to add the sync input that phase-aligns all enabled channels.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 27,
  parameter int DEFAULT_HALF = DEFAULT_HALF_1HZ_50MHZ
) (
  input  logic              clki,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  ch_idx_t           div_ch,
  input  logic [DIV_W-1:0]  div_data,
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clko,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_chWr;

  // Out-of-range channel indices match no channel, so such writes are dropped.
  always_comb begin
    w_chWr = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_chWr[ch] = div_wr && (div_ch == CH_IDX_W'(ch));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    clock_div_ch #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clki (clki),
      .rst  (rst),
      .en   (en[g]),
      .wr   (w_chWr[g]),
      .data (div_data),
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
      .sync (sync),
`endif
      .clko (clko[g]),
      .tick (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed self-checking bench for clock_div_multi with NUM_CH=2, DEFAULT_HALF=5.
module tb_clock_div_multi;

  logic       clki;
  logic       rst;
  logic [1:0] en;
  logic       div_wr;
  logic [3:0] div_ch;
  logic [7:0] div_data;
  logic       sync;
  logic [1:0] clko;
  logic [1:0] tick;

  int total;
  int bad;
  int n;

  clock_div_multi #(
    .NUM_CH       (2),
    .DIV_W        (8),
    .DEFAULT_HALF (5)
  ) dut (
    .clki     (clki),
    .rst      (rst),
    .en       (en),
    .div_wr   (div_wr),
    .div_ch   (div_ch),
    .div_data (div_data),
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
    .sync     (sync),
`endif
    .clko     (clko),
    .tick     (tick)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic step();
    @(posedge clki);
    #1;
  endtask

  // Counts edges until clko[ch] reaches lvl; 100 means it never did.
  task automatic wait_level(input int ch, input logic lvl, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (clko[ch] !== lvl && cnt < 100);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 2'b00;
    div_wr = 1'b0;
    sync = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write_half(input logic [3:0] ch, input logic [7:0] data);
    div_wr = 1'b1;
    div_ch = ch;
    div_data = data;
    step();
    div_wr = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if (clko !== 2'b00) begin bad++; $display("[TB] FAIL reset_clko: got %b expected 00", clko); end
    total++;
    if (tick !== 2'b00) begin bad++; $display("[TB] FAIL reset_tick: got %b expected 00", tick); end
    en = 2'b11;
    step();
    step();
    total++;
    if (clko !== 2'b00) begin bad++; $display("[TB] FAIL reset_hold_clko: got %b expected 00", clko); end
  endtask

  task automatic test_default_period();
    do_reset();
    en = 2'b11;
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL def_first_rise: got %0d expected 5", n); end
    total++;
    if (clko !== 2'b11) begin bad++; $display("[TB] FAIL def_both_high: got %b expected 11", clko); end
    total++;
    if (tick !== 2'b11) begin bad++; $display("[TB] FAIL def_tick_high: got %b expected 11", tick); end
    step();
    total++;
    if (tick !== 2'b00) begin bad++; $display("[TB] FAIL def_tick_one_cycle: got %b expected 00", tick); end
    wait_level(0, 1'b0, n);
    total++;
    if (n !== 4) begin bad++; $display("[TB] FAIL def_high_half: got %0d expected 4", n); end
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL def_low_half: got %0d expected 5", n); end
    total++;
    if (tick[0] !== 1'b1) begin bad++; $display("[TB] FAIL def_tick_again: got %b expected 1", tick[0]); end
  endtask

  task automatic test_reload_boundary();
    do_reset();
    en = 2'b10;
    wait_level(1, 1'b1, n);
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL rld_first_rise: got %0d expected 5", n); end
    step();
    step();
    write_half(4'd1, 8'd3);
    wait_level(1, 1'b0, n);
    total++;
    if (n !== 2) begin bad++; $display("[TB] FAIL rld_old_half_completes: got %0d expected 2", n); end
    wait_level(1, 1'b1, n);
    total++;
    if (n !== 3) begin bad++; $display("[TB] FAIL rld_new_low: got %0d expected 3", n); end
    wait_level(1, 1'b0, n);
    total++;
    if (n !== 3) begin bad++; $display("[TB] FAIL rld_new_high: got %0d expected 3", n); end
    total++;
    if (clko[0] !== 1'b0) begin bad++; $display("[TB] FAIL rld_ch0_idle: got %b expected 0", clko[0]); end
  endtask

  task automatic test_write_terminal();
    do_reset();
    en = 2'b01;
    for (int i = 0; i < 4; i++) step();
    write_half(4'd0, 8'd2);
    total++;
    if (clko[0] !== 1'b1) begin bad++; $display("[TB] FAIL wt_rise: got %b expected 1", clko[0]); end
    wait_level(0, 1'b0, n);
    total++;
    if (n !== 2) begin bad++; $display("[TB] FAIL wt_next_half: got %0d expected 2", n); end
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 2) begin bad++; $display("[TB] FAIL wt_following_half: got %0d expected 2", n); end
  endtask

  task automatic test_fastest();
    do_reset();
    write_half(4'd0, 8'd0);
    en = 2'b01;
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL fast_first_rise: got %0d expected 5", n); end
    step();
    total++;
    if (clko[0] !== 1'b0 || tick[0] !== 1'b0) begin bad++; $display("[TB] FAIL fast_fall: got clko=%b tick=%b expected 0 0", clko[0], tick[0]); end
    step();
    total++;
    if (clko[0] !== 1'b1 || tick[0] !== 1'b1) begin bad++; $display("[TB] FAIL fast_rise: got clko=%b tick=%b expected 1 1", clko[0], tick[0]); end
    step();
    total++;
    if (clko[0] !== 1'b0) begin bad++; $display("[TB] FAIL fast_fall2: got %b expected 0", clko[0]); end
  endtask

  task automatic test_bad_channel();
    do_reset();
    en = 2'b11;
    step();
    step();
    write_half(4'd7, 8'd2);
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 2) begin bad++; $display("[TB] FAIL badch_rise: got %0d expected 2", n); end
    total++;
    if (clko !== 2'b11) begin bad++; $display("[TB] FAIL badch_both_high: got %b expected 11", clko); end
    wait_level(0, 1'b0, n);
    total++;
    if (n !== 5 || clko !== 2'b00) begin bad++; $display("[TB] FAIL badch_fall: got n=%0d clko=%b expected 5 00", n, clko); end
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 5 || clko !== 2'b11) begin bad++; $display("[TB] FAIL badch_rise2: got n=%0d clko=%b expected 5 11", n, clko); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    en = 2'b01;
    wait_level(0, 1'b1, n);
    step();
    step();
    en = 2'b00;
    step();
    total++;
    if (clko[0] !== 1'b0 || tick[0] !== 1'b0) begin bad++; $display("[TB] FAIL en_drop: got clko=%b tick=%b expected 0 0", clko[0], tick[0]); end
    en = 2'b01;
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL en_restart: got %0d expected 5", n); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_half(4'd0, 8'd3);
    en = 2'b01;
    wait_level(0, 1'b1, n);
    wait_level(0, 1'b0, n);
    total++;
    if (n !== 3) begin bad++; $display("[TB] FAIL rm_programmed_half: got %0d expected 3", n); end
    wait_level(0, 1'b1, n);
    step();
    rst = 1'b1;
    #1;
    total++;
    if (clko !== 2'b00 || tick !== 2'b00) begin bad++; $display("[TB] FAIL rm_async_clear: got clko=%b tick=%b expected 00 00", clko, tick); end
    step();
    rst = 1'b0;
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL rm_default_rise: got %0d expected 5", n); end
    wait_level(0, 1'b0, n);
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL rm_default_half: got %0d expected 5", n); end
  endtask

`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
  task automatic test_sync();
    do_reset();
    write_half(4'd1, 8'd3);
    en = 2'b11;
    for (int i = 0; i < 7; i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    total++;
    if (clko !== 2'b00) begin bad++; $display("[TB] FAIL sync_clear: got %b expected 00", clko); end
    wait_level(1, 1'b1, n);
    total++;
    if (n !== 3 || clko[0] !== 1'b0) begin bad++; $display("[TB] FAIL sync_ch1_rise: got n=%0d clko0=%b expected 3 0", n, clko[0]); end
    wait_level(0, 1'b1, n);
    total++;
    if (n !== 2) begin bad++; $display("[TB] FAIL sync_ch0_rise: got %0d expected 2", n); end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 2'b00;
    div_wr = 1'b0;
    div_ch = 4'd0;
    div_data = 8'd0;
    sync = 1'b0;
    test_reset();
    test_default_period();
    test_reload_boundary();
    test_write_terminal();
    test_fastest();
    test_bad_channel();
    test_enable_drop();
    test_reset_mid();
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
    test_sync();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
